// File: rtl/dat_lane_ctrl.sv
// rtl/dat_lane_ctrl.sv - SD host DAT-line transfer controller
//
// Sequences single, counted multi-block and open-ended multi-block transfers
// between the host register block, the DAT serializer/deserializer wrapper,
// the DAT pad and the data FIFO.
//
// Optional feature macro: DAT_CRC_STATUS_CHECK_EN
//   defined   - write CRC-status token must be 3'b010, anything else ends the
//               transfer with crc_error set
//   undefined - the CRC-status token is ignored and crc_error stays 0
//
// Ports:
//   sd_clock, reset          clock, asynchronous active-high reset
//   strobe_in/ack_in/abort_in host request, completion ack, abort
//   write_read, multiple, blocks, timeout_reg  transfer setup (latched on start)
//   serial_ready, complete, ack_out            host handshake
//   data_timeout, crc_error, aborted           sticky status flags
//   blocks_done                                blocks finished this transfer
//   transmission_complete, reception_complete, crc_status, busy_in, data_read
//                                              wrapper / pad status inputs
//   reset_wrapper, load_send, enable_pts_wrapper, enable_stp_wrapper
//                                              wrapper controls
//   pad_state, pad_enable                      DAT pad direction / enable
//   fifo_empty, fifo_full, fifo_rd_en, fifo_wr_en, data_to_fifo
//                                              data FIFO side
module dat_lane_ctrl #(
  parameter int DATA_W      = 32,
  parameter int BLOCK_CNT_W = 8,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                   sd_clock,
  input  logic                   reset,
  input  logic                   strobe_in,
  input  logic                   ack_in,
  input  logic                   abort_in,
  input  logic                   write_read,
  input  logic                   multiple,
  input  logic [BLOCK_CNT_W-1:0] blocks,
  input  logic [TIMEOUT_W-1:0]   timeout_reg,
  output logic                   serial_ready,
  output logic                   complete,
  output logic                   ack_out,
  output logic                   data_timeout,
  output logic                   crc_error,
  output logic                   aborted,
  output logic [BLOCK_CNT_W-1:0] blocks_done,
  input  logic                   transmission_complete,
  input  logic                   reception_complete,
  input  logic [2:0]             crc_status,
  input  logic                   busy_in,
  input  logic [DATA_W-1:0]      data_read,
  output logic                   reset_wrapper,
  output logic                   load_send,
  output logic                   enable_pts_wrapper,
  output logic                   enable_stp_wrapper,
  output logic                   pad_state,
  output logic                   pad_enable,
  input  logic                   fifo_empty,
  input  logic                   fifo_full,
  output logic                   fifo_rd_en,
  output logic                   fifo_wr_en,
  output logic [DATA_W-1:0]      data_to_fifo
);

  typedef enum logic [3:0] {
    ST_RST, ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT_STATUS, ST_WAIT_BUSY,
    ST_READ, ST_READ_STORE, ST_READ_REARM, ST_DONE
  } state_t;

  localparam logic [BLOCK_CNT_W-1:0] BLK_ONE = 1;
  localparam logic [TIMEOUT_W-1:0]   TMO_ONE = 1;

  state_t                 state, state_next;
  logic                   multiple_q;
  logic [BLOCK_CNT_W-1:0] blocks_q;
  logic [TIMEOUT_W-1:0]   timeout_q, tmo_cnt;
  logic                   abort_pend;

  logic start, set_tmo, set_crc, set_abort, inc_blk, cap_data, pend_abort;
  logic last_blk, tmo_hit, crc_bad, timed_state, tmo_clr;

  // blocks == 0 with multiple set never matches: open-ended transfers only end on abort.
  assign last_blk = !multiple_q || ((blocks_q != '0) && ((blocks_done + BLK_ONE) == blocks_q));
  // Fires on the timeout_reg-th cycle spent in a timed state.
  assign tmo_hit  = (timeout_q != '0) && ((tmo_cnt + TMO_ONE) == timeout_q);

`ifdef DAT_CRC_STATUS_CHECK_EN
  assign crc_bad = (crc_status != 3'b010);
`else
  // Status token is not inspected in this build.
  logic unused_crc_status;
  assign unused_crc_status = ^crc_status;
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) state <= ST_RST;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    serial_ready = 1'b0; complete = 1'b0; ack_out = 1'b0;
    reset_wrapper = 1'b0; load_send = 1'b0;
    enable_pts_wrapper = 1'b0; enable_stp_wrapper = 1'b0;
    pad_state = 1'b0; pad_enable = 1'b0;
    fifo_rd_en = 1'b0; fifo_wr_en = 1'b0;
    start = 1'b0; set_tmo = 1'b0; set_crc = 1'b0; set_abort = 1'b0;
    inc_blk = 1'b0; cap_data = 1'b0; pend_abort = 1'b0;
    case (state)
      ST_RST: state_next = ST_IDLE;
      ST_IDLE: begin
        serial_ready = 1'b1; reset_wrapper = 1'b1;
        if (strobe_in) begin
          start = 1'b1;
          state_next = write_read ? ST_LOAD : ST_READ;
        end
      end
      ST_LOAD: begin
        pad_state = 1'b1; pad_enable = 1'b1; enable_pts_wrapper = 1'b1;
        if (abort_in) begin
          set_abort = 1'b1; state_next = ST_DONE;
        end else if (!fifo_empty) begin
          fifo_rd_en = 1'b1; state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        load_send = 1'b1; enable_pts_wrapper = 1'b1; pad_state = 1'b1; pad_enable = 1'b1;
        if (abort_in) begin
          set_abort = 1'b1; state_next = ST_DONE;
        end else if (transmission_complete) state_next = ST_WAIT_STATUS;
      end
      ST_WAIT_STATUS: begin
        pad_enable = 1'b1; enable_stp_wrapper = 1'b1;
        if (abort_in) begin
          set_abort = 1'b1; state_next = ST_DONE;
        end else if (tmo_hit) begin
          set_tmo = 1'b1; state_next = ST_DONE;
        end else if (reception_complete) begin
          if (crc_bad) begin
            set_crc = 1'b1; state_next = ST_DONE;
          end else state_next = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        // The card owns DAT0 while busy; an abort is remembered and acted on at release.
        if (busy_in) begin
          pend_abort = abort_in;
          if (tmo_hit) begin
            set_tmo = 1'b1; state_next = ST_DONE;
          end
        end else begin
          inc_blk = 1'b1;
          if (abort_in || abort_pend) begin
            set_abort = 1'b1; state_next = ST_DONE;
          end else state_next = last_blk ? ST_DONE : ST_LOAD;
        end
      end
      ST_READ: begin
        pad_enable = 1'b1; enable_stp_wrapper = 1'b1;
        if (abort_in) begin
          set_abort = 1'b1; state_next = ST_DONE;
        end else if (tmo_hit) begin
          set_tmo = 1'b1; state_next = ST_DONE;
        end else if (reception_complete) begin
          cap_data = 1'b1; state_next = ST_READ_STORE;
        end
      end
      ST_READ_STORE: begin
        if (abort_in) begin
          set_abort = 1'b1; state_next = ST_DONE;
        end else if (!fifo_full) begin
          fifo_wr_en = 1'b1; inc_blk = 1'b1;
          state_next = last_blk ? ST_DONE : ST_READ_REARM;
        end
      end
      ST_READ_REARM: begin
        reset_wrapper = 1'b1;
        if (abort_in) begin
          set_abort = 1'b1; state_next = ST_DONE;
        end else state_next = ST_READ;
      end
      ST_DONE: begin
        complete = 1'b1; ack_out = ack_in;
        if (ack_in) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign timed_state = (state == ST_WAIT_STATUS) || (state == ST_WAIT_BUSY) || (state == ST_READ);
  assign tmo_clr = (state_next != state) &&
                   ((state_next == ST_WAIT_STATUS) || (state_next == ST_WAIT_BUSY) ||
                    (state_next == ST_READ));

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      multiple_q <= 1'b0; blocks_q <= '0; timeout_q <= '0; tmo_cnt <= '0;
      abort_pend <= 1'b0; data_timeout <= 1'b0; crc_error <= 1'b0; aborted <= 1'b0;
      blocks_done <= '0; data_to_fifo <= '0;
    end else begin
      if (start) begin
        multiple_q <= multiple; blocks_q <= blocks; timeout_q <= timeout_reg;
        abort_pend <= 1'b0; data_timeout <= 1'b0; crc_error <= 1'b0; aborted <= 1'b0;
        blocks_done <= '0;
      end
      if (set_tmo)    data_timeout <= 1'b1;
      if (set_crc)    crc_error <= 1'b1;
      if (set_abort)  aborted <= 1'b1;
      if (pend_abort) abort_pend <= 1'b1;
      if (inc_blk && (blocks_done != '1)) blocks_done <= blocks_done + BLK_ONE;
      if (cap_data)   data_to_fifo <= data_read;
      if (tmo_clr)          tmo_cnt <= '0;
      else if (timed_state) tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end

endmodule
